// File: rtl/ram_be_pipe.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, collision control and a post-reset clear engine.
// Optional per-byte even parity storage and checking is enabled by defining RAM_BYTE_PARITY_EN.
module ram_be_pipe #(
    parameter int Width     = 32,
    parameter int Depth     = 1024,
    parameter int RdLatency = 1,
    parameter int Bypass    = 0,
    localparam int NB = Width / 8,
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [Width-1:0] wrData,
    input  logic [NB-1:0]    wrBe,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [Width-1:0] rdData,
    output logic             rdValid,
    output logic             initBusy,
    output logic             parityErr
);

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    localparam logic [AW:0] DepthW = (AW+1)'(Depth);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            init_busy_q, init_busy_d;

    logic [Width-1:0] mem [Depth];
`ifdef RAM_BYTE_PARITY_EN
    logic [NB-1:0]    par_mem [Depth];
    logic [NB-1:0]    rd_par;
`endif

    logic             ready, wr_ok, rd_accept, rd_in_range;
    logic [Width-1:0] rd_word;
    logic             rd_perr;

    logic             s1_valid_q, s1_valid_d;
    logic [Width-1:0] s1_data_q, s1_data_d;
    logic             s1_perr_q, s1_perr_d;

    assign ready       = (state_q == ST_READY);
    assign wr_ok       = ready && wrEn && ({1'b0, wrAddr} < DepthW);
    assign rd_accept   = ready && rdEn;
    assign rd_in_range = ({1'b0, rdAddr} < DepthW);

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == AW'(Depth - 1)) begin
                    state_d     = ST_READY;
                    init_busy_d = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // The clear engine owns the write port until READY; user writes are ignored meanwhile.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_addr_q] <= '0;
`ifdef RAM_BYTE_PARITY_EN
            par_mem[clr_addr_q] <= '0;
`endif
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wrBe[i]) begin
                    mem[wrAddr][8*i +: 8] <= wrData[8*i +: 8];
`ifdef RAM_BYTE_PARITY_EN
                    par_mem[wrAddr][i] <= ^wrData[8*i +: 8];
`endif
                end
            end
        end
    end

    // Forwarded bytes carry fresh data, so they can never flag a parity mismatch.
    always_comb begin
        rd_word = '0;
        rd_perr = 1'b0;
`ifdef RAM_BYTE_PARITY_EN
        rd_par  = '0;
`endif
        if (rd_in_range) begin
            rd_word = mem[rdAddr];
`ifdef RAM_BYTE_PARITY_EN
            rd_par  = par_mem[rdAddr];
`endif
            for (int i = 0; i < NB; i++) begin
                if ((Bypass != 0) && wr_ok && (wrAddr == rdAddr) && wrBe[i]) begin
                    rd_word[8*i +: 8] = wrData[8*i +: 8];
                end
`ifdef RAM_BYTE_PARITY_EN
                else if ((^rd_word[8*i +: 8]) != rd_par[i]) begin
                    rd_perr = 1'b1;
                end
`endif
            end
        end
    end

    // rdEn is a request with no back-pressure: every request accepted in READY produces exactly
    // one rdValid pulse RdLatency edges later; data holds between pulses.
    always_comb begin
        s1_valid_d = rd_accept;
        s1_data_d  = rd_accept ? rd_word : s1_data_q;
        s1_perr_d  = rd_accept && rd_perr;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            init_busy_q <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_perr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_busy_q <= init_busy_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_perr_q   <= s1_perr_d;
        end
    end

    generate
        if (RdLatency == 2) begin : g_lat2
            logic             s2_valid_q, s2_valid_d;
            logic [Width-1:0] s2_data_q, s2_data_d;
            logic             s2_perr_q, s2_perr_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
                s2_perr_d  = s1_valid_q && s1_perr_q;
            end

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_perr_q  <= 1'b0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                    s2_perr_q  <= s2_perr_d;
                end
            end

            assign rdValid   = s2_valid_q;
            assign rdData    = s2_data_q;
            assign parityErr = s2_perr_q;
        end else begin : g_lat1
            assign rdValid   = s1_valid_q;
            assign rdData    = s1_data_q;
            assign parityErr = s1_perr_q;
        end
    endgenerate

    assign initBusy = init_busy_q;

endmodule

// File: tb/tb_ram_be_pipe.sv
// Bench for ram_be_pipe: three instances (lat1/read-first, lat2/write-first, Depth=12) share one stimulus stream.
// Expected read results go into per-instance queues; monitors pop them on rdValid.
module tb_ram_be_pipe;
    localparam int W  = 32;
    localparam int EW = W + 1;

    logic          clk = 1'b0;
    logic          rstN;
    logic          wrEn, rdEn;
    logic [3:0]    wrAddr, rdAddr, wrBe;
    logic [W-1:0]  wrData;

    logic [W-1:0]  rd_data0, rd_data1, rd_data2;
    logic          rd_valid0, rd_valid1, rd_valid2;
    logic          init_busy0, init_busy1, init_busy2;
    logic          perr0, perr1, perr2;

    logic [EW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
    logic [EW-1:0] e0, e1, e2;
    logic [W-1:0]  model16 [16];
    logic [W-1:0]  model12 [12];
    int            checks = 0;
    int            passes = 0;
`ifdef RAM_BYTE_PARITY_EN
    bit            par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    ram_be_pipe #(.Width(32), .Depth(16), .RdLatency(1), .Bypass(0)) u0 (
        .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrBe(wrBe),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rd_data0), .rdValid(rd_valid0),
        .initBusy(init_busy0), .parityErr(perr0));

    ram_be_pipe #(.Width(32), .Depth(16), .RdLatency(2), .Bypass(1)) u1 (
        .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrBe(wrBe),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rd_data1), .rdValid(rd_valid1),
        .initBusy(init_busy1), .parityErr(perr1));

    ram_be_pipe #(.Width(32), .Depth(12), .RdLatency(1), .Bypass(0)) u2 (
        .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrBe(wrBe),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rd_data2), .rdValid(rd_valid2),
        .initBusy(init_busy2), .parityErr(perr2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rd_valid0) begin
            if (exp_q0.size() == 0) check("u0_spurious_valid", 64'(rd_valid0), 64'd0);
            else begin
                e0 = exp_q0.pop_front();
                check("u0_read", 64'({perr0, rd_data0}), 64'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid1) begin
            if (exp_q1.size() == 0) check("u1_spurious_valid", 64'(rd_valid1), 64'd0);
            else begin
                e1 = exp_q1.pop_front();
                check("u1_read", 64'({perr1, rd_data1}), 64'(e1));
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid2) begin
            if (exp_q2.size() == 0) check("u2_spurious_valid", 64'(rd_valid2), 64'd0);
            else begin
                e2 = exp_q2.pop_front();
                check("u2_read", 64'({perr2, rd_data2}), 64'(e2));
            end
        end
    end

    // One request cycle: drives inputs at the negedge, queues expected reads, then updates the models.
    task automatic cycle(input bit we, input logic [3:0] wa, input logic [W-1:0] wd,
                         input logic [3:0] wbe, input bit re, input logic [3:0] ra);
        logic [W-1:0] old16, merged, old12;
        logic         pe;
        @(negedge clk);
        wrEn = we; wrAddr = wa; wrData = wd; wrBe = wbe;
        rdEn = re; rdAddr = ra;
        if (re) begin
            old16  = model16[ra];
            merged = old16;
            for (int i = 0; i < 4; i++)
                if (we && (wa == ra) && wbe[i]) merged[8*i +: 8] = wd[8*i +: 8];
            old12 = (ra < 4'd12) ? model12[ra] : '0;
            pe = 1'b0;
`ifdef RAM_BYTE_PARITY_EN
            pe = par_flip && (ra == 4'd3);
`endif
            exp_q0.push_back({1'b0, old16});
            exp_q1.push_back({1'b0, merged});
            exp_q2.push_back({pe, old12});
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    model16[wa][8*i +: 8] = wd[8*i +: 8];
                    if (wa < 4'd12) model12[wa][8*i +: 8] = wd[8*i +: 8];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, '0, 4'd0, 1'b0, 4'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) model16[i] = '0;
        for (int i = 0; i < 12; i++) model12[i] = '0;
        rstN = 1'b0; wrEn = 1'b0; rdEn = 1'b0; wrAddr = '0; rdAddr = '0; wrData = '0; wrBe = '0;
        repeat (2) @(negedge clk);
        check("rst_rd_data", 64'({rd_data0, rd_data1}), 64'd0);
        check("rst_rd_data2", 64'(rd_data2), 64'd0);
        check("rst_valid", 64'({rd_valid0, rd_valid1, rd_valid2}), 64'd0);
        check("rst_perr", 64'({perr0, perr1, perr2}), 64'd0);
        check("rst_busy", 64'({init_busy0, init_busy1, init_busy2}), 64'b111);

        // First clear attempt, interrupted at clrAddr == 9 while requests are being driven.
        rstN = 1'b1;
        wrEn = 1'b1; wrAddr = 4'd2; wrData = 32'hDEADBEEF; wrBe = 4'hF;
        rdEn = 1'b1; rdAddr = 4'd2;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("clear1_busy", 64'({init_busy0, init_busy1, init_busy2}), 64'b111);
        end
        rstN = 1'b0;
        @(negedge clk);
        check("midclear_rst_busy", 64'({init_busy0, init_busy1, init_busy2}), 64'b111);
        rstN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("clear2_busy16", 64'({init_busy0, init_busy1}), (k < 16) ? 64'b11 : 64'b00);
            check("clear2_busy12", 64'(init_busy2), (k < 12) ? 64'd1 : 64'd0);
            if (k == 10) begin
                wrEn = 1'b0; rdEn = 1'b0;
            end
        end

        // Every address reads zero after clear (addr 2 shows the CLEAR-time write was dropped).
        for (int a = 0; a < 16; a++) cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'(a));
        idle(4);

        // Byte-enable merge: expect 0xAA22CC44.
        cycle(1'b1, 4'd5, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0);
        cycle(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'd5);
        idle(3);

        // Back-to-back reads with latency checks.
        for (int a = 0; a < 4; a++) cycle(1'b1, 4'(a), 32'(a), 4'hF, 1'b0, 4'd0);
        for (int k = 0; k <= 6; k++) begin
            if (k < 4) cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'(k));
            else idle(1);
            check("lat1_valid", 64'(rd_valid0), ((k >= 1) && (k <= 4)) ? 64'd1 : 64'd0);
            check("lat2_valid", 64'(rd_valid1), ((k >= 2) && (k <= 5)) ? 64'd1 : 64'd0);
        end
        idle(3);
        check("hold_data0", 64'(rd_data0), 64'd3);
        check("hold_data1", 64'(rd_data1), 64'd3);
        check("hold_valid", 64'({rd_valid0, rd_valid1, rd_valid2}), 64'd0);

        // Read/write collision at addr 7, then a plain re-read.
        cycle(1'b1, 4'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 4'd7);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'd7);
        idle(3);

        // Out-of-range for the 12-deep instance.
        cycle(1'b1, 4'd13, 32'h12345678, 4'hF, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'd13);
        idle(3);

`ifdef RAM_BYTE_PARITY_EN
        @(negedge clk);
        u2.par_mem[3][1] = ~u2.par_mem[3][1];
        par_flip = 1'b1;
`endif
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'd3);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 4'd13);
        idle(5);

        check("q0_drained", 64'(exp_q0.size()), 64'd0);
        check("q1_drained", 64'(exp_q1.size()), 64'd0);
        check("q2_drained", 64'(exp_q2.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ram_be_pipe.md
Name: ram_be_pipe

Overview:
Simple dual-port synchronous RAM with one write port and one read port. It adds per-byte write enables, a gated read with a valid flag, a selectable read latency of 1 or 2, and defined read-during-write collision behaviour. A built-in clear engine zeroes the whole array after reset. It is the general-purpose storage block for buffers and lookup tables across the design.

Parameters:
Width, 32, data width in bits; must be a multiple of 8; NB = Width/8 byte lanes.
Depth, 1024, number of words; need not be a power of 2; AW = max(1, $clog2(Depth)).
RdLatency, 1, read latency in cycles; legal values 1 or 2.
Bypass, 0, collision mode: 0 = read-first (old data), 1 = write-first (new bytes forwarded).

Ports:
clk  in  1  clock; all logic on the rising edge.
rstN  in  1  asynchronous, active-low reset.
wrEn  in  1  write request.
wrAddr  in  AW  write address.
wrData  in  Width  write data.
wrBe  in  NB  byte enables; bit i covers wrData[8i+7:8i].
rdEn  in  1  read request.
rdAddr  in  AW  read address.
rdData  out  Width  read data; registered.
rdValid  out  1  one-cycle pulse per accepted read, aligned with rdData.
initBusy  out  1  high while the clear engine runs; requests are ignored.
parityErr  out  1  parity mismatch flag, aligned with rdValid.

Behaviour:
- Reset (rstN low, asynchronous):
  - rdData = 0, rdValid = 0, parityErr = 0, initBusy = 1.
  - FSM goes to CLEAR, clear counter clrAddr = 0.
  - Pipeline registers are cleared. Memory is not reset directly.
- FSM state CLEAR:
  - Each edge writes all-zero data (and zero parity) to mem[clrAddr], then increments clrAddr.
  - At clrAddr == Depth-1 the write happens and the FSM moves to READY.
  - initBusy falls after exactly Depth edges following reset release.
  - wrEn and rdEn are ignored; rdValid stays 0.
- FSM state READY: terminal until the next reset. Reset mid-clear restarts at clrAddr = 0.
- Write (READY, wrEn = 1): at the edge, for each byte i with wrBe[i] = 1, mem[wrAddr] byte i <= wrData byte i; other bytes unchanged. wrBe = 0 means no write.
- Read (READY, rdEn = 1 at edge N):
  - RdLatency = 1: rdData and rdValid update at edge N.
  - RdLatency = 2: they update at edge N+1 through an extra output register.
  - Back-to-back reads give continuous rdValid, one word per cycle, no bubbles.
  - rdData holds its last value while rdValid = 0.
- Collision (wrEn and rdEn at the same edge, wrAddr == rdAddr):
  - Bypass = 0: rdData is the pre-write word.
  - Bypass = 1: byte i is wrData byte i where wrBe[i] = 1, otherwise the old byte.
  - The write always completes.
- Out of range (address >= Depth, non-power-of-2 Depth only):
  - Write is dropped.
  - Read returns 0 with rdValid = 1 and parityErr = 0.
- rdAddr is sampled only when rdEn = 1; wrData and wrBe only when wrEn = 1.

Optional Feature:
RAM_BYTE_PARITY_EN
- Defined:
  - One even-parity bit per byte lane is stored alongside data and written under the same wrBe.
  - On read, parity is recomputed per byte; parityErr = OR of mismatches, registered and aligned with rdValid.
  - With Bypass = 1, forwarded bytes use freshly computed parity.
- Not defined: no parity storage; parityErr tied to 0.

Test Plan:
1. Reset release, Depth=16 → initBusy high for exactly 16 edges, then low; a read of every address returns 0x00000000 with rdValid pulses.
2. Write 0xAABBCCDD to addr 5 with wrBe=4'hF, then 0x11223344 with wrBe=4'b0101 → read of addr 5 returns 0xAA22CC44.
3. RdLatency=2: rdEn on 4 consecutive cycles, addrs 0..3 holding 0,1,2,3 → rdValid high for 4 cycles starting 2 edges after the first request; data 0,1,2,3 in order.
4. Collision at addr 7 (old 0x00000000), wrData 0xFFFFFFFF, wrBe=4'b0011 → Bypass=0 reads 0x00000000; Bypass=1 reads 0x0000FFFF; a subsequent read gives 0x0000FFFF in both modes.
5. rstN pulsed low mid-clear (clrAddr=9), plus requests during CLEAR → clear restarts at 0; initBusy stays high for a further full Depth edges; no rdValid and no writes land during CLEAR.
6. RAM_BYTE_PARITY_EN with Depth=12: bench flips the stored parity bit for addr 3 byte 1 by hierarchical deposit → read of addr 3 gives parityErr=1 coincident with rdValid; a read of addr 13 returns 0 with parityErr=0.
